// File: rtl/wb_master_fsm.sv
// Wishbone burst master fed by the message queue head: request, incremental burst, queue handshake.
// Optional beat watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_fsm #(
  parameter int N_BITS_BURST_LENGHT = 7,
  parameter int BUS_ADDRESS_WIDTH   = 32,
  parameter int BUS_DATA_WIDTH      = 32,
  parameter int BUS_SEL_WIDTH       = 4,
  parameter int ADDR_INC            = 4,
  parameter int BACKOFF_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           r_bus_arbitration_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
  input  logic [BUS_DATA_WIDTH-1:0]      data_i,
  input  logic [BUS_SEL_WIDTH-1:0]       sel_i,
  input  logic                           transaction_type_i,
  input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
  output logic                           next_data_o,
  output logic                           retry_o,
  output logic                           message_transmitted_o,
  input  logic                           gnt_i,
  output logic                           cyc_o,
  output logic                           stb_o,
  output logic                           we_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]   adr_o,
  output logic [BUS_DATA_WIDTH-1:0]      dat_o,
  output logic [BUS_SEL_WIDTH-1:0]       sel_o,
  output logic [2:0]                     cti_o,
  input  logic                           ack_i,
  input  logic                           rty_i,
  input  logic                           err_i,
  input  logic [BUS_DATA_WIDTH-1:0]      dat_i,
  output logic [BUS_DATA_WIDTH-1:0]      rd_data_o,
  output logic                           rd_valid_o,
  output logic                           err_o
);

  typedef enum logic [1:0] {IDLE, REQ, BURST, BACKOFF} state_t;

  localparam int NB   = N_BITS_BURST_LENGHT;
  localparam int BO_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [NB-1:0] ONE = NB'(1);

  state_t                 state_q, state_d;
  logic [NB-1:0]          len_q, len_d;
  logic [NB-1:0]          beat_cnt_q, beat_cnt_d;
  logic [BO_W-1:0]        backoff_cnt_q, backoff_cnt_d;
  logic                   we_q, we_d;
  logic [BUS_DATA_WIDTH-1:0] rd_data_q;
  logic                   rd_valid_q;
  logic                   rd_beat;
  logic                   last_beat;
  logic                   any_resp;
  logic                   timeout_hit;

  assign last_beat = (beat_cnt_q == len_q - ONE);
  assign any_resp  = ack_i | rty_i | err_i;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Fires only on a silent cycle, so a real response always wins over the watchdog.
  assign timeout_hit = (state_q == BURST) && !any_resp && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == BURST && !any_resp && !timeout_hit) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d               = state_q;
    len_d                 = len_q;
    we_d                  = we_q;
    beat_cnt_d            = beat_cnt_q;
    backoff_cnt_d         = backoff_cnt_q;
    cyc_o                 = 1'b0;
    stb_o                 = 1'b0;
    we_o                  = 1'b0;
    adr_o                 = '0;
    dat_o                 = '0;
    sel_o                 = '0;
    cti_o                 = 3'b000;
    next_data_o           = 1'b0;
    retry_o               = 1'b0;
    message_transmitted_o = 1'b0;
    err_o                 = 1'b0;
    rd_beat               = 1'b0;
    case (state_q)
      IDLE: begin
        if (r_bus_arbitration_i) begin
          len_d   = (burst_lenght_i == '0) ? ONE : burst_lenght_i;
          we_d    = transaction_type_i;
          state_d = REQ;
        end
      end
      REQ: begin
        cyc_o = 1'b1;
        if (gnt_i) begin
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = we_q;
        adr_o = address_i + BUS_ADDRESS_WIDTH'(beat_cnt_q) * BUS_ADDRESS_WIDTH'(ADDR_INC);
        dat_o = data_i;
        sel_o = sel_i;
        cti_o = last_beat ? 3'b111 : 3'b010;
        if (err_i) begin
          message_transmitted_o = 1'b1;
          err_o                 = 1'b1;
          state_d               = IDLE;
        end else if (rty_i || timeout_hit) begin
          retry_o       = 1'b1;
          beat_cnt_d    = '0;
          backoff_cnt_d = '0;
          state_d       = BACKOFF;
        end else if (ack_i) begin
          rd_beat = !we_q;
          if (last_beat) begin
            message_transmitted_o = 1'b1;
            state_d               = IDLE;
          end else begin
            next_data_o = 1'b1;
            beat_cnt_d  = beat_cnt_q + ONE;
          end
        end
      end
      BACKOFF: begin
        if (backoff_cnt_q == BO_W'(BACKOFF_CYCLES - 1)) begin
          backoff_cnt_d = '0;
          state_d       = REQ;
        end else begin
          backoff_cnt_d = backoff_cnt_q + BO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      we_q          <= 1'b0;
      beat_cnt_q    <= '0;
      backoff_cnt_q <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      we_q          <= we_d;
      beat_cnt_q    <= beat_cnt_d;
      backoff_cnt_q <= backoff_cnt_d;
      rd_valid_q    <= rd_beat;
      if (rd_beat) rd_data_q <= dat_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_wb_master_fsm.sv
// Bench for wb_master_fsm: the bench plays message queue and Wishbone slave, and predicts every
// beat and handshake from the message contents and slave responses.
module tb_wb_master_fsm;
  localparam int NB  = 7;
  localparam int INC = 4;
  localparam int BO  = 4;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_bus_arbitration_i = 1'b0;
  logic [31:0]   address_i = '0;
  logic [31:0]   data_i = '0;
  logic [3:0]    sel_i = '0;
  logic          transaction_type_i = 1'b0;
  logic [NB-1:0] burst_lenght_i = '0;
  logic          next_data_o, retry_o, message_transmitted_o;
  logic          gnt_i = 1'b0;
  logic          cyc_o, stb_o, we_o;
  logic [31:0]   adr_o, dat_o;
  logic [3:0]    sel_o;
  logic [2:0]    cti_o;
  logic          ack_i = 1'b0, rty_i = 1'b0, err_i = 1'b0;
  logic [31:0]   dat_i = '0;
  logic [31:0]   rd_data_o;
  logic          rd_valid_o, err_o;

  wb_master_fsm #(
    .N_BITS_BURST_LENGHT(NB), .BUS_ADDRESS_WIDTH(32), .BUS_DATA_WIDTH(32), .BUS_SEL_WIDTH(4),
    .ADDR_INC(INC), .BACKOFF_CYCLES(BO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .r_bus_arbitration_i(r_bus_arbitration_i), .address_i(address_i),
    .data_i(data_i), .sel_i(sel_i), .transaction_type_i(transaction_type_i),
    .burst_lenght_i(burst_lenght_i), .next_data_o(next_data_o), .retry_o(retry_o),
    .message_transmitted_o(message_transmitted_o), .gnt_i(gnt_i), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .cti_o(cti_o), .ack_i(ack_i),
    .rty_i(rty_i), .err_i(err_i), .dat_i(dat_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Message held by the "queue" and slave behaviour knobs
  logic [31:0] msg_data[128];
  logic [3:0]  msg_sel[128];
  int          resp_q[$];          // per-STB-cycle response: bit0 ack, bit1 rty, bit2 err
  bit          resp_rand = 0;
  bit          gnt_rand  = 0;
  bit          rd_seq    = 0;
  int          cnt_nd, cnt_rty, cnt_mt, cnt_err, cnt_rv, first_stb, first_rty;
  logic [31:0] rd_got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int rand_code();
    int r = $urandom_range(0, 99);
    if (r < 60) return 1;
    if (r < 85) return 0;
    if (r < 93) return 2;
    if (r < 97) return 4;
    return 7;
  endfunction

  task automatic fill_msg(input int len);
    for (int k = 0; k < len && k < 128; k++) begin
      msg_data[k] = $urandom;
      msg_sel[k]  = 4'($urandom);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, {31'd0, cyc_o}, 0);
    chk({tag, "_stb"}, {31'd0, stb_o}, 0);
    chk({tag, "_we"}, {31'd0, we_o}, 0);
    chk({tag, "_adr"}, adr_o, 0);
    chk({tag, "_dat"}, dat_o, 0);
    chk({tag, "_sel"}, {28'd0, sel_o}, 0);
    chk({tag, "_cti"}, {29'd0, cti_o}, 0);
    chk({tag, "_rdv"}, {31'd0, rd_valid_o}, 0);
    chk({tag, "_rdd"}, rd_data_o, 0);
    chk({tag, "_hs"}, {29'd0, next_data_o, retry_o, message_transmitted_o}, 0);
    chk({tag, "_err"}, {31'd0, err_o}, 0);
  endtask

  // Presents one message at the queue head and plays it to completion, checking every cycle.
  task automatic run_msg(input logic [31:0] addr, input int len_field, input logic we, input int budget);
    int len_eff = (len_field == 0) ? 1 : len_field;
    int ptr = 0, quiet = 0, nores = 0, cyc_n = 0, code;
    bit must_req = 0, done = 0, exp_rv = 0, nxt_rv, to_hit;
    bit a, r, e, exp_nd, exp_rt, exp_mt, exp_er;
    logic [31:0] exp_rd = '0, nxt_rd;
    cnt_nd = 0; cnt_rty = 0; cnt_mt = 0; cnt_err = 0; cnt_rv = 0;
    first_stb = -1; first_rty = -1;
    rd_got.delete();
    while (1) begin
      @(posedge clk); #1;
      cyc_n++;
      if (cyc_n > budget) begin
        chk("cycle_budget", cyc_n, budget);
        break;
      end
      r_bus_arbitration_i = !done;
      address_i          = addr;
      burst_lenght_i     = NB'(len_field);
      transaction_type_i = we;
      data_i             = msg_data[ptr];
      sel_i              = msg_sel[ptr];
      gnt_i              = gnt_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
      {a, r, e} = 3'b000;
      if (stb_o) begin
        if (resp_q.size() > 0) code = resp_q.pop_front();
        else if (resp_rand)    code = rand_code();
        else                   code = 1;
        a = code[0]; r = code[1]; e = code[2];
      end
      ack_i = a; rty_i = r; err_i = e;
      dat_i = rd_seq ? 32'(ptr + 1) : $urandom;
      #1;
      chk("rd_valid", {31'd0, rd_valid_o}, {31'd0, exp_rv});
      if (exp_rv) chk("rd_data", rd_data_o, exp_rd);
      if (rd_valid_o) begin cnt_rv++; rd_got.push_back(rd_data_o); end
      if (cyc_n == 1) chk("start_idle_cyc", {31'd0, cyc_o}, 0);
      if (cyc_n == 2) chk("req_after_idle", {30'd0, cyc_o, stb_o}, 32'd2);
      if (quiet > 0) begin
        chk("backoff_cyc", {31'd0, cyc_o}, 0);
        quiet--;
        if (quiet == 0) must_req = 1;
      end else if (must_req) begin
        chk("rereq", {30'd0, cyc_o, stb_o}, 32'd2);
        must_req = 0;
      end
      if (done) begin
        chk("idle_after_msg", {31'd0, cyc_o}, 0);
        chk("idle_hs", {29'd0, next_data_o, retry_o, message_transmitted_o}, 0);
        break;
      end
      {exp_nd, exp_rt, exp_mt, exp_er, nxt_rv, to_hit} = 6'b0;
      nxt_rd = exp_rd;
      if (stb_o) begin
        if (first_stb < 0) first_stb = cyc_n;
        chk("cyc_with_stb", {31'd0, cyc_o}, 1);
        chk("we", {31'd0, we_o}, {31'd0, we});
        chk("adr", adr_o, addr + 32'(ptr) * INC);
        chk("cti", {29'd0, cti_o}, (ptr == len_eff - 1) ? 32'd7 : 32'd2);
        chk("dat_o", dat_o, msg_data[ptr]);
        chk("sel", {28'd0, sel_o}, {28'd0, msg_sel[ptr]});
`ifdef WB_MASTER_TIMEOUT_EN
        to_hit = !a && !r && !e && (nores == TO);
`endif
        if (e) begin exp_mt = 1; exp_er = 1; end
        else if (r || to_hit) exp_rt = 1;
        else if (a) begin
          nxt_rv = !we;
          nxt_rd = dat_i;
          if (ptr == len_eff - 1) exp_mt = 1; else exp_nd = 1;
        end
        nores = (a || r || e || to_hit) ? 0 : nores + 1;
      end else begin
        nores = 0;
      end
      chk("next_data", {31'd0, next_data_o}, {31'd0, exp_nd});
      chk("retry", {31'd0, retry_o}, {31'd0, exp_rt});
      chk("msg_tx", {31'd0, message_transmitted_o}, {31'd0, exp_mt});
      chk("err_o", {31'd0, err_o}, {31'd0, exp_er});
      cnt_nd += int'(next_data_o); cnt_rty += int'(retry_o);
      cnt_mt += int'(message_transmitted_o); cnt_err += int'(err_o);
      if (retry_o && first_rty < 0) first_rty = cyc_n;
      if (exp_nd) ptr++;
      if (exp_rt) begin ptr = 0; quiet = BO; end
      if (exp_mt) done = 1;
      exp_rv = nxt_rv;
      exp_rd = nxt_rd;
    end
    ack_i = 0; rty_i = 0; err_i = 0; gnt_i = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 0;

    // Single write, immediate grant and ack
    fill_msg(1);
    msg_data[0] = 32'hA5A5A5A5;
    run_msg(32'h1000, 1, 1'b1, 50);
    chk("t1_first_stb", first_stb, 3);
    chk("t1_mt", cnt_mt, 1);
    chk("t1_nd", cnt_nd, 0);
    $display("t1 single write: mt=%0d nd=%0d", cnt_mt, cnt_nd);

    // 4-beat write burst
    fill_msg(4);
    run_msg(32'h2000, 4, 1'b1, 50);
    chk("t2_nd", cnt_nd, 3);
    chk("t2_mt", cnt_mt, 1);
    $display("t2 burst write: nd=%0d mt=%0d", cnt_nd, cnt_mt);

    // 4-beat read with an ack gap after beat 2
    fill_msg(4);
    rd_seq = 1;
    resp_q = '{1, 1, 0, 1, 1};
    run_msg(32'h3000, 4, 1'b0, 50);
    rd_seq = 0;
    chk("t3_rv", cnt_rv, 4);
    for (int k = 0; k < 4; k++) chk("t3_rd_seq", (k < rd_got.size()) ? rd_got[k] : 32'hX, 32'(k + 1));
    $display("t3 burst read: rd_valid=%0d", cnt_rv);

    // Retry on beat 3 of 4, restart and complete
    fill_msg(4);
    resp_q = '{1, 1, 2};
    run_msg(32'h4000, 4, 1'b1, 60);
    chk("t4_rty", cnt_rty, 1);
    chk("t4_nd", cnt_nd, 5);
    chk("t4_mt", cnt_mt, 1);
    $display("t4 retry: rty=%0d nd=%0d mt=%0d", cnt_rty, cnt_nd, cnt_mt);

    // err, rty and ack together on beat 1
    fill_msg(2);
    resp_q = '{7};
    run_msg(32'h5000, 2, 1'b1, 50);
    chk("t5_err", cnt_err, 1);
    chk("t5_mt", cnt_mt, 1);
    chk("t5_rty_nd", cnt_rty + cnt_nd, 0);
    $display("t5 err priority: err=%0d mt=%0d", cnt_err, cnt_mt);

    // Zero length is one beat; address wrap across the top of the space
    fill_msg(1);
    run_msg(32'h6000, 0, 1'b1, 50);
    chk("len0_mt", cnt_mt, 1);
    chk("len0_nd", cnt_nd, 0);
    fill_msg(4);
    run_msg(32'hFFFF_FFF8, 4, 1'b0, 50);
    chk("wrap_rv", cnt_rv, 4);
    $display("boundary: len0 and wrap done");

    // Randomised messages, grants and slave responses
    resp_rand = 1;
    gnt_rand  = 1;
    for (int m = 0; m < 40; m++) begin
      int len = ($urandom_range(0, 4) == 0) ? $urandom_range(9, 20) : $urandom_range(0, 8);
      logic wr = 1'($urandom);
      fill_msg(len);
      run_msg($urandom, len, wr, 2000);
      chk("rand_mt", cnt_mt, 1);
      $display("rand msg %0d: len=%0d we=%0d nd=%0d rty=%0d err=%0d", m, len, wr, cnt_nd, cnt_rty, cnt_err);
    end
    resp_rand = 0;
    gnt_rand  = 0;

    // Reset mid-burst
    @(posedge clk); #1;
    fill_msg(4);
    r_bus_arbitration_i = 1; address_i = 32'h7000; burst_lenght_i = NB'(4);
    transaction_type_i = 1; gnt_i = 1; ack_i = 0; data_i = msg_data[0];
    for (int c = 0; c < 10 && !stb_o; c++) begin @(posedge clk); #1; end
    chk("rst_mid_stb_seen", {31'd0, stb_o}, 1);
    rst = 1;
    @(posedge clk); #1;
    chk_all_zero("rst_mid");
    rst = 0; r_bus_arbitration_i = 0; gnt_i = 0;
    @(posedge clk); #1;
    chk("rst_mid_idle", {31'd0, cyc_o}, 0);
    $display("reset mid-burst: cyc=%0d", cyc_o);

`ifdef WB_MASTER_TIMEOUT_EN
    // Watchdog: no response for TO cycles
    fill_msg(2);
    resp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_msg(32'h8000, 2, 1'b1, 80);
    chk("to_latency", first_rty - first_stb, TO);
    chk("to_mt", cnt_mt, 1);
    $display("timeout: retry %0d cycles after stb", first_rty - first_stb);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_master_fsm.md
Name: wb_master_fsm

Overview:
- Wishbone master engine directly downstream of the PACKET2MESSAGE message queue.
- Takes the queue's head message (address, per-beat data, sel, we, burst length) and acquires the bus. Runs an incremental burst, then reports next_data, retry or message_transmitted back to the queue.
- Read-beat data is forwarded to the response path.

Parameters:
- N_BITS_BURST_LENGHT, 7, width of burst length and beat counter
- BUS_ADDRESS_WIDTH, 32, Wishbone address width
- BUS_DATA_WIDTH, 32, Wishbone data width
- BUS_SEL_WIDTH, 4, Wishbone SEL width
- ADDR_INC, 4, byte address increment per beat
- BACKOFF_CYCLES, 4, idle cycles after a retry before re-requesting the bus (minimum 1)
- TIMEOUT_CYCLES, 255, beat watchdog limit (only with WB_MASTER_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- r_bus_arbitration_i  in  1  queue has a message at head
- address_i  in  BUS_ADDRESS_WIDTH  base address of head message
- data_i  in  BUS_DATA_WIDTH  current data chunk from queue
- sel_i  in  BUS_SEL_WIDTH  current SEL
- transaction_type_i  in  1  1=write, 0=read
- burst_lenght_i  in  N_BITS_BURST_LENGHT  beats in message
- next_data_o  out  1  advance queue chunk pointer
- retry_o  out  1  restart current message
- message_transmitted_o  out  1  pop head message
- gnt_i  in  1  bus arbiter grant
- cyc_o  out  1  WB CYC (also bus request)
- stb_o  out  1  WB STB
- we_o  out  1  WB WE
- adr_o  out  BUS_ADDRESS_WIDTH  WB ADR
- dat_o  out  BUS_DATA_WIDTH  WB DAT write
- sel_o  out  BUS_SEL_WIDTH  WB SEL
- cti_o  out  3  WB CTI
- ack_i  in  1  WB ACK
- rty_i  in  1  WB RTY
- err_i  in  1  WB ERR
- dat_i  in  BUS_DATA_WIDTH  WB DAT read
- rd_data_o  out  BUS_DATA_WIDTH  registered read beat
- rd_valid_o  out  1  rd_data_o valid, 1-cycle pulse
- err_o  out  1  message dropped on bus error, 1-cycle pulse

Behaviour:

Reset:
- state=IDLE, beat_cnt=0, backoff_cnt=0.
- cyc_o, stb_o, we_o, rd_valid_o, err_o = 0; adr_o, dat_o, sel_o, cti_o, rd_data_o = 0.
- Reset mid-burst drops CYC/STB at the next edge; no queue handshake is issued.

FSM states:
- IDLE:
  - cyc_o=0.
  - If r_bus_arbitration_i: latch len=max(burst_lenght_i,1) and we=transaction_type_i; go to REQ.
- REQ:
  - cyc_o=1, stb_o=0.
  - If gnt_i: go to BURST with beat_cnt=0.
- BURST:
  - cyc_o=stb_o=1, we_o=latched we.
  - adr_o = address_i + beat_cnt*ADDR_INC, truncated to BUS_ADDRESS_WIDTH (wraps).
  - dat_o=data_i, sel_o=sel_i.
  - cti_o: 3'b111 when beat_cnt==len-1, otherwise 3'b010. BTE is implicitly linear.
  - gnt_i is ignored once in BURST.
- BACKOFF:
  - cyc_o=0.
  - Count BACKOFF_CYCLES, then go to REQ.

Beat termination in BURST (combinational outputs, same cycle as the WB response):
- Priority is err_i > rty_i > ack_i.
- ack_i, not last beat:
  - next_data_o=1, beat_cnt+1.
  - The next beat is presented the following cycle with STB held high.
- ack_i, last beat:
  - message_transmitted_o=1, go to IDLE.
  - cyc_o=0 the following cycle.
  - IDLE always spends at least 1 cycle before a new REQ.
- rty_i:
  - retry_o=1, beat_cnt=0, go to BACKOFF.
  - next_data_o is not asserted.
- err_i:
  - message_transmitted_o=1 and err_o=1 (message discarded), go to IDLE.

Reads:
- On every ack_i with we=0: rd_data_o<=dat_i and rd_valid_o<=1 one cycle later.
- Read beats already delivered before a retry are re-delivered on the restart; the consumer handles duplicates.

Output invariants:
- next_data_o, retry_o and message_transmitted_o are mutually exclusive.
- Each is high only in BURST.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - A watchdog counts BURST cycles with no ack_i, rty_i or err_i; it clears on any response.
  - When the count reaches TIMEOUT_CYCLES, act exactly as rty_i: retry_o pulse, go to BACKOFF.
- Undefined: no counter; BURST waits for a response indefinitely.

Test Plan:
1. Single write: len=1, we=1, address 0x1000, data 0xA5A5A5A5, gnt and ack immediate → REQ 1 cycle, one STB beat with adr 0x1000 and cti 3'b111, message_transmitted_o pulse on the ack cycle, cyc_o=0 next cycle.
2. 4-beat write burst, base 0x2000, ack on every cycle → adr 0x2000/0x2004/0x2008/0x200C, cti 010,010,010,111, three next_data_o pulses then one message_transmitted_o.
3. 4-beat read with an ack gap after beat 2 → rd_valid_o pulses 4 times carrying dat_i values 1,2,3,4 one cycle after each ack; STB held during the gap.
4. rty_i on beat 3 of 4 → retry_o pulse, cyc_o low for 4 cycles, then re-request; restart at the base address with beat_cnt=0; transfer then completes normally.
5. ack_i, rty_i and err_i asserted together on beat 1 → err_o and message_transmitted_o pulse, no retry_o, no next_data_o, FSM in IDLE.
6. rst asserted mid-burst; separately, with WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack → all outputs 0 after rst; timeout case gives retry_o exactly 8 cycles after STB rises.
